comps_array: RTL and testbench
==============================

COMPS_ARRAY -- requirements
Module: comps_array

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent compare channels (1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flip-flop synchroniser depth on every raw input (2..4).
REQ-003 SHALL have parameter DEB_W, default 4, width of the debounce length and debounce counters.
REQ-004 SHALL have parameter CNT_W, default 8, width of each per-channel event counter.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: wb_clk_i  input  1  clock; wb_rst_i  input  1  async reset, active high.
REQ-006 SHALL have port a  input  1  asynchronous global enable; synchronised, not debounced.
REQ-007 SHALL have port b  input  CHANNELS  asynchronous operand B per channel.
REQ-008 SHALL have port c  input  CHANNELS  asynchronous operand C per channel.
REQ-009 SHALL have port mode  input  2  compare function, synchronous to wb_clk_i.
REQ-010 SHALL have port deb_len  input  DEB_W  debounce length D, synchronous to wb_clk_i.
REQ-011 SHALL have port clr  input  1  synchronous clear of all event counters.
REQ-012 SHALL have port w  output  1  OR of all x bits.
REQ-013 SHALL have port x  output  CHANNELS  registered compare result per channel.
REQ-014 SHALL have port y  output  CHANNELS  one-cycle pulse on each rising edge of x.
REQ-015 SHALL have port count  output  CHANNELS*CNT_W  packed event counters; channel i at bits [i*CNT_W +: CNT_W].

Function
REQ-016 SHALL pass a, every b[i] and every c[i] through a SYNC_STAGES-deep synchroniser; synchronised values are sa, sb[i], sc[i].
REQ-017 SHALL debounce sb[i] and sc[i] separately, each with its own filtered bit f and DEB_W-bit counter k.
REQ-018 Debounce: s==f -> k<=0; s!=f and k<D -> k<=k+1; s!=f and k==D -> f<=s, k<=0. So f follows s after D+1 consecutive differing cycles; D=0 gives 1 cycle.
REQ-019 SHALL treat a glitch shorter than D+1 cycles at the synchroniser output as noise: f unchanged, k returns to 0.
REQ-020 A change of deb_len SHALL apply on the next clock edge; if a running k already exceeds the new D, the next differing cycle SHALL update f.
REQ-021 Compare on filtered bits fb, fc: mode 00 -> fb==fc; 01 -> fb&~fc; 10 -> ~fb&fc; 11 -> fb^fc.
REQ-022 x[i] SHALL be registered: x[i] <= sa & cmp[i]; sa=0 forces x to 0 on the next edge.
REQ-023 y[i] SHALL be registered together with x: y[i] <= next_x[i] & ~x[i]. y is high for exactly one cycle, in the same cycle x rises.
REQ-024 Latency from a stable raw-input change to x change SHALL be SYNC_STAGES + D + 2 clock edges. A mode change or a change of sa SHALL reach x in 1 or SYNC_STAGES+1 edges respectively.
REQ-025 count[i] SHALL increment by 1 on the edge after each y[i] pulse, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-026 clr SHALL set every count to 0 on the next edge. clr and a pending increment in the same cycle -> result 0 (clr wins).
REQ-027 w SHALL be the combinational OR of the registered x bits; no extra latency.
REQ-028 Channels SHALL be fully independent; activity on one channel SHALL NOT change the x, y or count of another.

Reset
REQ-029 Asserting wb_rst_i SHALL immediately clear all synchroniser flops, f, k, x, y and count to 0, so w=0, x=0, y=0 and count=0, with no clock required.
REQ-030 Reset asserted mid-debounce or mid-count SHALL discard all progress. After deassertion, the block SHALL restart as though the inputs had just changed from 0.

Verification
REQ-031 Setup CHANNELS=2, SYNC_STAGES=2, D=3, mode=00, a=1; b[0]=1, c[0]=0 -> b[0] 1->0 held -> x[0] rises exactly 7 edges after the input change; y[0] pulses 1 cycle; count[0]=1 one edge later; w=1.
REQ-032 D=3, c[1] pulsed 1 for 3 cycles, other channel-1 inputs 0, mode=11 -> x[1] stays 0, y[1] never pulses, count[1] unchanged.
REQ-033 mode=01, D=0, b[0]=1 and c[0]=0 stable, then 300 toggles of a (each phase 10 cycles) -> count[0] saturates at 255 and stays 255.
REQ-034 clr asserted in the same cycle a y[0] pulse is pending an increment -> count[0]=0 on the next edge, not 1.
REQ-035 wb_rst_i asserted asynchronously between clock edges while x=2'b11 and count[0]=5 -> x, y, w and count all 0 before the next edge. After release with inputs unchanged, x returns to 2'b11 after SYNC_STAGES+D+2 edges.
REQ-036 a=0 while the compare is true on both channels -> x=0 and w=0 within SYNC_STAGES+1 edges. Then a=1 -> both y bits pulse simultaneously and both counts increment.

Source files
------------

// File: rtl/comps_array.sv
// comps_array: per-channel synchronised, debounced two-operand compare with
// registered result, rising-edge pulse and saturating event counter.
//
// Ports:
//   wb_clk_i  clock
//   wb_rst_i  asynchronous active-high reset
//   a         asynchronous global enable (synchronised only)
//   b, c      asynchronous operands, one bit per channel
//   mode      compare function: 00 eq, 01 b&~c, 10 ~b&c, 11 xor
//   deb_len   debounce length D (filtered bit follows after D+1 cycles)
//   clr       synchronous clear of every event counter
//   w         OR of all x bits
//   x         registered compare result per channel
//   y         one-cycle pulse in the cycle x rises
//   count     packed saturating counters, channel i at [i*CNT_W +: CNT_W]
module comps_array #(
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 4,
    parameter int CNT_W       = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      a,
    input  logic [CHANNELS-1:0]       b,
    input  logic [CHANNELS-1:0]       c,
    input  logic [1:0]                mode,
    input  logic [DEB_W-1:0]          deb_len,
    input  logic                      clr,
    output logic                      w,
    output logic [CHANNELS-1:0]       x,
    output logic [CHANNELS-1:0]       y,
    output logic [CHANNELS*CNT_W-1:0] count
);

    localparam int RAW_W = 2 * CHANNELS + 1;
    localparam int NDEB  = 2 * CHANNELS;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

    // Raw inputs bundled so one synchroniser chain covers them all:
    // bit 0 is a, then b[CHANNELS-1:0], then c[CHANNELS-1:0].
    logic [RAW_W-1:0] raw;
    logic [RAW_W-1:0] sync_q [SYNC_STAGES];

    assign raw = {c, b, a};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    logic            sa;
    logic [NDEB-1:0] s_in;

    // s_in low half is sb, high half is sc.
    assign sa   = sync_q[SYNC_STAGES-1][0];
    assign s_in = sync_q[SYNC_STAGES-1][RAW_W-1:1];

    // Debouncers: one filtered bit and counter per synchronised operand bit.
    // Using >= lets a counter that already passed a newly shortened D
    // commit on the very next differing cycle.
    logic [NDEB-1:0]  f_q;
    logic [DEB_W-1:0] k_q [NDEB];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            f_q <= '0;
            for (int i = 0; i < NDEB; i++) begin
                k_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NDEB; i++) begin
                if (s_in[i] == f_q[i]) begin
                    k_q[i] <= '0;
                end else if (k_q[i] >= deb_len) begin
                    f_q[i] <= s_in[i];
                    k_q[i] <= '0;
                end else begin
                    k_q[i] <= k_q[i] + DEB_ONE;
                end
            end
        end
    end

    logic [CHANNELS-1:0] fb;
    logic [CHANNELS-1:0] fc;
    logic [CHANNELS-1:0] cmp;
    logic [CHANNELS-1:0] next_x;

    assign fb = f_q[CHANNELS-1:0];
    assign fc = f_q[NDEB-1:CHANNELS];

    always_comb begin
        cmp = '0;
        case (mode)
            2'b00:   cmp = ~(fb ^ fc);
            2'b01:   cmp = fb & ~fc;
            2'b10:   cmp = ~fb & fc;
            default: cmp = fb ^ fc;
        endcase
    end

    assign next_x = {CHANNELS{sa}} & cmp;

    // y is registered alongside x so the pulse lines up with the rise.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= next_x;
            y <= next_x & ~x;
        end
    end

    // Event counters advance on the edge after a y pulse; clr has priority.
    logic [CNT_W-1:0] cnt_q [CHANNELS];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (y[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
        assign count[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign w = |x;

endmodule

// File: tb/tb_comps_array.sv
// tb_comps_array: scoreboard bench for comps_array with default parameters.
// Expected rise events are queued at drive time and retired on y pulses.
module tb_comps_array;

    localparam int CH  = 2;
    localparam int CW  = 8;
    localparam int DW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a   = 1'b0;
    logic [CH-1:0] b   = 2'b01;
    logic [CH-1:0] c   = 2'b00;
    logic [1:0]    mode    = 2'b00;
    logic [DW-1:0] deb_len = 4'd3;
    logic          clr = 1'b0;
    logic          w;
    logic [CH-1:0] x;
    logic [CH-1:0] y;
    logic [CH*CW-1:0] count;

    comps_array #(
        .CHANNELS(CH),
        .SYNC_STAGES(2),
        .DEB_W(DW),
        .CNT_W(CW)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .a(a),
        .b(b),
        .c(c),
        .mode(mode),
        .deb_len(deb_len),
        .clr(clr),
        .w(w),
        .x(x),
        .y(y),
        .count(count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        int ch;
        int at;
    } ev_t;

    ev_t sb_q[$];
    int  ecnt[CH];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_rise(input int ch, input int at);
        ev_t e;
        e.ch = ch;
        e.at = at;
        sb_q.push_back(e);
        if (ecnt[ch] < 255) ecnt[ch]++;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        ecnt[0] = 0;
        ecnt[1] = 0;
    endtask

    function automatic logic [CH*CW-1:0] exp_count();
        return {ecnt[1][CW-1:0], ecnt[0][CW-1:0]};
    endfunction

    // Retire queued rises as y pulses appear.
    int idx;
    always @(negedge clk) begin
        if (!rst) begin
            for (int ch = 0; ch < CH; ch++) begin
                if (y[ch]) begin
                    idx = -1;
                    for (int j = 0; j < sb_q.size(); j++) begin
                        if (idx < 0 && sb_q[j].ch == ch) idx = j;
                    end
                    if (idx < 0) begin
                        check($sformatf("y_spur%0d", ch), {31'd0, y[ch]}, 32'd0);
                    end else begin
                        check($sformatf("rise_at%0d", ch), cyc, sb_q[idx].at);
                        sb_q.delete(idx);
                    end
                end
            end
        end
    end

    int m;

    initial begin
        ecnt[0] = 0;
        ecnt[1] = 0;

        // Async reset with no clock edge yet.
        #1 rst = 1'b1;
        #1;
        check("rst_x", {30'd0, x}, 32'd0);
        check("rst_y", {30'd0, y}, 32'd0);
        check("rst_w", {31'd0, w}, 32'd0);
        check("rst_cnt", {16'd0, count}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Enable gated off: nothing rises.
        step(20);
        check("gate_x", {30'd0, x}, 32'd0);

        // Enable on: ch1 equal (0==0) rises, ch0 (1 vs 0) does not.
        a = 1'b1;
        push_rise(1, cyc + 3);
        step(10);
        check("en_x", {30'd0, x}, 32'h2);
        do_clr();
        check("clr_cnt", {16'd0, count}, 32'd0);

        // b[0] 1->0: x[0] rises exactly 7 edges later.
        m = cyc;
        b = 2'b00;
        push_rise(0, m + 7);
        step(6);
        check("lat_x0_pre", {31'd0, x[0]}, 32'd0);
        step(1);
        check("lat_x0", {31'd0, x[0]}, 32'd1);
        check("lat_y0", {31'd0, y[0]}, 32'd1);
        check("lat_w", {31'd0, w}, 32'd1);
        step(1);
        check("lat_y0_off", {31'd0, y[0]}, 32'd0);
        check("lat_cnt0", {24'd0, count[7:0]}, 32'd1);
        check("lat_cnt1", {24'd0, count[15:8]}, 32'd0);

        // xor mode, 3-cycle glitch on c[1] is filtered.
        mode = 2'b11;
        step(3);
        check("xor_x", {30'd0, x}, 32'd0);
        c = 2'b10;
        step(3);
        c = 2'b00;
        step(20);
        check("glitch_x1", {31'd0, x[1]}, 32'd0);
        check("glitch_cnt", {16'd0, count}, {16'd0, exp_count()});

        // 4-cycle pulse (D+1) gets through.
        m = cyc;
        c = 2'b10;
        push_rise(1, m + 7);
        step(4);
        c = 2'b00;
        step(3);
        check("pass_x1", {31'd0, x[1]}, 32'd1);
        check("pass_x0", {31'd0, x[0]}, 32'd0);
        step(1);
        check("pass_cnt", {16'd0, count}, {16'd0, exp_count()});
        step(3);
        check("pass_x1_off", {31'd0, x[1]}, 32'd0);
        step(10);

        // Both compares true; enable drop then return.
        mode = 2'b00;
        push_rise(0, cyc + 1);
        push_rise(1, cyc + 1);
        step(5);
        check("both_x", {30'd0, x}, 32'h3);
        a = 1'b0;
        step(2);
        check("aoff_x_pre", {30'd0, x}, 32'h3);
        step(1);
        check("aoff_x", {30'd0, x}, 32'd0);
        check("aoff_w", {31'd0, w}, 32'd0);
        step(5);
        a = 1'b1;
        push_rise(0, cyc + 3);
        push_rise(1, cyc + 3);
        step(4);
        check("aon_cnt", {16'd0, count}, {16'd0, exp_count()});

        // clr coincides with a pending increment: clr wins.
        a = 1'b0;
        step(5);
        a = 1'b1;
        push_rise(0, cyc + 3);
        push_rise(1, cyc + 3);
        step(3);
        check("clrw_y", {30'd0, y}, 32'h3);
        do_clr();
        check("clrw_cnt", {16'd0, count}, 32'd0);
        step(5);
        check("clrw_hold", {16'd0, count}, 32'd0);

        // Build x=11 with debounced operands, then count 5 events.
        mode = 2'b11;
        b = 2'b11;
        c = 2'b00;
        push_rise(0, cyc + 7);
        push_rise(1, cyc + 7);
        step(10);
        do_clr();
        for (int i = 0; i < 5; i++) begin
            a = 1'b0;
            step(5);
            a = 1'b1;
            push_rise(0, cyc + 3);
            push_rise(1, cyc + 3);
            step(5);
        end
        check("pre_rst_x", {30'd0, x}, 32'h3);
        check("pre_rst_c0", {24'd0, count[7:0]}, 32'd5);

        // Async reset mid-cycle.
        #3 rst = 1'b1;
        #1;
        check("arst_x", {30'd0, x}, 32'd0);
        check("arst_y", {30'd0, y}, 32'd0);
        check("arst_w", {31'd0, w}, 32'd0);
        check("arst_cnt", {16'd0, count}, 32'd0);
        ecnt[0] = 0;
        ecnt[1] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m = cyc;
        push_rise(0, m + 7);
        push_rise(1, m + 7);
        step(6);
        check("rel_x_pre", {30'd0, x}, 32'd0);
        step(1);
        check("rel_x", {30'd0, x}, 32'h3);
        step(1);
        check("rel_cnt", {16'd0, count}, {16'd0, exp_count()});

        // Saturation: mode 01, D=0, ch1 compare false.
        a = 1'b0;
        b = 2'b01;
        c = 2'b00;
        mode = 2'b01;
        deb_len = 4'd0;
        step(10);
        do_clr();
        for (int i = 0; i < 300; i++) begin
            a = 1'b1;
            push_rise(0, cyc + 3);
            step(10);
            if (i == 254 || i == 255 || i == 299) begin
                check($sformatf("sat_c0_%0d", i), {24'd0, count[7:0]},
                      ecnt[0]);
            end
            a = 1'b0;
            step(10);
        end
        check("sat_c0", {24'd0, count[7:0]}, 32'd255);
        check("sat_c1", {24'd0, count[15:8]}, 32'd0);

        step(5);
        check("sb_left", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
